seq_mul_param: RTL and testbench
================================

Name: seq_mul_param

Overview:
- Parametrised, iterative shift-add multiplier. It is the sequential successor to the team's 8x8 combinational array multiplier.
- Trades area for latency: the single full-width adder is reused over WIDTH cycles.
- Supports unsigned and two's-complement signed operands, selected per transaction.
- Sits between a producer and a consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32. The product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, width of the internal iteration counter. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- in_signed  input  1  1 = operands are two's complement; 0 = unsigned. Sampled with the operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts the product.
- p  output  2*WIDTH  product; signed or unsigned according to the captured in_signed.
- busy  output  1  high in BUSY state.

Behaviour:
- Clock and reset: one clock, clk. rst_n is an asynchronous, active-low reset.
- Reset values (taken immediately on rst_n low, regardless of state):
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - busy = 0
  - p = 0
  - all internal registers = 0
- A reset asserted mid-operation aborts the operation. No product is emitted for it.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, capture:
    - sgn = in_signed & (a[MSB] ^ b[MSB])
    - mcand = |a| (absolute value only when in_signed = 1), zero-extended to 2*WIDTH
    - mplr = |b| (absolute value only when in_signed = 1)
    - acc = 0
    - cnt = 0
  - Go to BUSY.
- Magnitude rule: the magnitude of the most-negative value (e.g. -128 at WIDTH = 8) is 2^(WIDTH-1). This fits unsigned in WIDTH bits and must not overflow.
- BUSY (busy = 1, in_ready = 0), every cycle:
  - If mplr[0] = 1: acc = acc + (mcand << cnt), computed at 2*WIDTH bits with no carry lost.
  - mplr = mplr >> 1.
  - cnt = cnt + 1.
  - On the cycle where cnt == WIDTH-1, finish instead of continuing:
    - Load p with the sign-corrected final sum: sgn ? -(acc_next) : acc_next.
    - out_valid = 1.
    - Go to DONE.
- Latency: out_valid rises exactly WIDTH clock edges after the accept edge.
- DONE:
  - out_valid = 1 and in_ready = 0.
  - p is held stable until the handshake.
  - On out_ready = 1: out_valid = 0 and go to IDLE. in_ready is high in the following cycle.
  - The minimum issue interval is WIDTH+2 cycles.
- Back-pressure: out_ready may stay low indefinitely. p and out_valid must not change while waiting.
- in_valid asserted while in BUSY or DONE is ignored, because in_ready = 0.
- Signed result range: at WIDTH = 8, -128 * -128 = 16384 = 0x4000, which fits in 16 bits. No saturation is needed for any legal input.
- Unsigned full scale: at WIDTH = 8, 255 * 255 = 65025 = 0xFE01.

Optional Feature:
- Macro: SEQ_MUL_EARLY_TERM_EN.
- When defined:
  - BUSY also finishes on the cycle where (mplr >> 1) == 0 after the current bit is processed, i.e. no set bits remain.
  - Latency = max(1, position of the highest set bit of |b| + 1) cycles.
  - b = 0 gives a latency of 1.
  - Results are identical to the build without the macro.
- When undefined: fixed latency of WIDTH cycles, with no comparator logic.

Test Plan:
- Reset/idle: rst_n low, then released → in_ready = 1, out_valid = 0, p = 0, busy = 0.
- Unsigned, WIDTH = 8: a = 255, b = 255, in_signed = 0 → p = 0xFE01. out_valid rises 8 edges after acceptance (fixed build).
- Signed, WIDTH = 8:
  - a = 0x80 (-128), b = 0x80 → p = 0x4000.
  - a = 0xFD (-3), b = 7 → p = 0xFFEB (-21).
  - a = 5, b = 0 → p = 0.
- Back-pressure: hold out_ready = 0 for 20 cycles after out_valid → p is stable and in_ready stays 0. A new in_valid pulse during that time is ignored. Release out_ready → in_ready = 1 on the next cycle.
- Reset mid-operation: assert rst_n low 3 cycles into BUSY → immediately IDLE with out_valid = 0. A fresh operation a = 12, b = 11 then yields p = 132.
- SEQ_MUL_EARLY_TERM_EN build: b = 1 → latency 1; b = 0x10 → latency 5; b = 0 → latency 1. Random 1000-pair unsigned/signed comparison against a reference model for both builds, plus WIDTH = 16 with a = 0xFFFF, b = 0xFFFF → p = 0xFFFE0001.

Source files
------------

// File: rtl/seq_mul_param.sv
// rtl/seq_mul_param.sv - iterative shift-add multiplier, signed/unsigned, valid/ready both sides
// Optional macro SEQ_MUL_EARLY_TERM_EN: finish as soon as no multiplier bits remain.
module seq_mul_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   p,
    output logic                 busy
);
    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic             sgn;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [WIDTH-1:0] mplr;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    acc_next;
    logic [PW-1:0]    result;
    logic             last_step;
    logic             accept;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    // Negating the most-negative value wraps to 2^(WIDTH-1), which is exactly the magnitude wanted.
    always_comb begin
        a_mag = (in_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag = (in_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    end

    always_comb begin
        partial  = mplr[0] ? (mcand << cnt) : '0;
        acc_next = acc + partial;
        result   = sgn ? (~acc_next + PW'(1)) : acc_next;
`ifdef SEQ_MUL_EARLY_TERM_EN
        last_step = (cnt == LAST_CNT) || ((mplr >> 1) == '0);
`else
        last_step = (cnt == LAST_CNT);
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn   <= 1'b0;
            mcand <= '0;
            acc   <= '0;
            mplr  <= '0;
            cnt   <= '0;
            p     <= '0;
        end else if (accept) begin
            sgn   <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            mcand <= {{WIDTH{1'b0}}, a_mag};
            acc   <= '0;
            mplr  <= b_mag;
            cnt   <= '0;
        end else if (state == BUSY) begin
            acc  <= acc_next;
            mplr <= mplr >> 1;
            cnt  <= cnt + CNT_W'(1);
            if (last_step) begin
                p <= result;
            end
        end
    end
endmodule

// File: tb/tb_seq_mul_param.sv
// tb/tb_seq_mul_param.sv - randomized and directed checks of seq_mul_param at WIDTH 8 and 16
`timescale 1ns/1ps
module tb_seq_mul_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid = 0, in_signed = 0, out_ready = 0;
    logic [7:0]  a = 0, b = 0;
    logic        in_ready, out_valid, busy;
    logic [15:0] p;

    logic        in_valid16 = 0, in_signed16 = 0, out_ready16 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        in_ready16, out_valid16, busy16;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;

    seq_mul_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .a(a), .b(b), .out_valid(out_valid),
        .out_ready(out_ready), .p(p), .busy(busy)
    );

    seq_mul_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .in_signed(in_signed16), .a(a16), .b(b16), .out_valid(out_valid16),
        .out_ready(out_ready16), .p(p16), .busy(busy16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input int w, input logic [63:0] x,
                                            input logic [63:0] y, input bit s);
        longint sx, sy, pr;
        logic [63:0] mask;
        sx = longint'(x);
        sy = longint'(y);
        if (s && x[w-1]) sx = sx - (longint'(1) << w);
        if (s && y[w-1]) sy = sy - (longint'(1) << w);
        pr = sx * sy;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(pr) & mask;
    endfunction

    function automatic int lat_exp(input int w, input logic [63:0] y, input bit s);
`ifdef SEQ_MUL_EARLY_TERM_EN
        logic [63:0] mag;
        int top;
        mag = (s && y[w-1]) ? ((64'd1 << w) - y) : y;
        top = 0;
        for (int i = 0; i < w; i++) if (mag[i]) top = i;
        return top + 1;
`else
        return w + (y == y ? 0 : 1);
`endif
    endfunction

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input bit s,
                       input int hold, input bit poke);
        logic [63:0] ep;
        int el, lat;
        ep = ref_mul(8, 64'(av), 64'(bv), s);
        el = lat_exp(8, 64'(bv), s);
        chk("w8_in_ready_idle", 64'(in_ready), 64'd1);
        a = av; b = bv; in_signed = s; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("w8_busy", 64'(busy), 64'd1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("w8_latency", 64'(lat), 64'(el));
        chk("w8_product", 64'(p), ep);
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1;
                a = 8'($urandom);
                b = 8'($urandom);
            end
            tick();
            chk("w8_hold_p", 64'(p), ep);
            chk("w8_hold_valid", 64'(out_valid), 64'd1);
            chk("w8_hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("w8_out_valid_drop", 64'(out_valid), 64'd0);
        chk("w8_in_ready_back", 64'(in_ready), 64'd1);
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input bit s);
        logic [63:0] ep;
        int el, lat;
        ep = ref_mul(16, 64'(av), 64'(bv), s);
        el = lat_exp(16, 64'(bv), s);
        chk("w16_in_ready_idle", 64'(in_ready16), 64'd1);
        a16 = av; b16 = bv; in_signed16 = s; in_valid16 = 1'b1;
        tick();
        in_valid16 = 1'b0;
        lat = 0;
        while (out_valid16 !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("w16_latency", 64'(lat), 64'(el));
        chk("w16_product", 64'(p16), ep);
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        chk("w16_out_valid_drop", 64'(out_valid16), 64'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_p", 64'(p), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_p", 64'(p), 64'd0);

        op8(8'hFF, 8'hFF, 1'b0, 0, 1'b0);
        chk("full_scale_const", 64'(p), 64'hFE01);
        op8(8'h80, 8'h80, 1'b1, 0, 1'b0);
        chk("neg_sq_const", 64'(p), 64'h4000);
        op8(8'hFD, 8'h07, 1'b1, 0, 1'b0);
        chk("neg3x7_const", 64'(p), 64'hFFEB);
        op8(8'h05, 8'h00, 1'b1, 0, 1'b0);
        op8(8'h05, 8'h01, 1'b0, 0, 1'b0);
        op8(8'h09, 8'h10, 1'b0, 0, 1'b0);
        op8(8'h7F, 8'h80, 1'b1, 0, 1'b0);

        op8(8'hC3, 8'h5A, 1'b0, 20, 1'b1);
        op8(8'h21, 8'h03, 1'b0, 0, 1'b0);

        a = 8'd99; b = 8'd77; in_signed = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_p", 64'(p), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        op8(8'd12, 8'd11, 1'b0, 0, 1'b0);
        chk("after_abort_const", 64'(p), 64'd132);

        for (int i = 0; i < 1000; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                (i % 7 == 0) ? 2 : 0, 1'b0);
        end

        op16(16'hFFFF, 16'hFFFF, 1'b0);
        chk("w16_full_scale_const", 64'(p16), 64'hFFFE0001);
        op16(16'h8000, 16'h8000, 1'b1);
        for (int i = 0; i < 200; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
